// File: rtl/uart_pkt_framer.sv
// uart_pkt_framer
//   Builds a UART packet from a header request and an AXI-stream payload:
//   0x5A, TYPE, LEN_H, LEN_L, PAYLOAD[0..LEN-1], CRC_H, CRC_L.
//   The CRC is CRC-16/CCITT-FALSE over TYPE..last payload byte (SOF excluded).
//   If CRC_EN is 0, the CRC bytes are sent as zero.
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   hdr_valid/hdr_ready header handshake; hdr_type, hdr_len are sampled on accept
//   s_tdata/s_tvalid/s_tready/s_tlast   payload stream input
//   m_tdata/m_tvalid/m_tready           framed byte stream to the serializer
//   busy                from header accept until the frame (and any drain) ends
//   len_err             one-cycle pulse on oversize header or tlast/length mismatch
module uart_pkt_framer #(
  parameter int MAX_LEN = 1518,
  parameter bit CRC_EN  = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hdr_valid,
  output logic        hdr_ready,
  input  logic [7:0]  hdr_type,
  input  logic [15:0] hdr_len,
  input  logic [7:0]  s_tdata,
  input  logic        s_tvalid,
  output logic        s_tready,
  input  logic        s_tlast,
  output logic [7:0]  m_tdata,
  output logic        m_tvalid,
  input  logic        m_tready,
  output logic        busy,
  output logic        len_err
);

  typedef enum logic [3:0] {
    IDLE, SOF, TYPE, LEN_H, LEN_L, PAYLOAD, CRC_H, CRC_L, DRAIN
  } state_t;

  localparam logic [16:0] MAX_LEN_W = 17'(MAX_LEN);

  state_t      state;
  logic [7:0]  type_q;
  logic [15:0] len_q;
  logic [15:0] cnt;
  logic [15:0] crc;
  logic        pad;   // early tlast seen: remaining payload is zero-filled
  logic        late;  // last byte arrived without tlast: drain after CRC_L

  logic adv;
  logic m_hs;
  logic s_hs;
  logic pay_phase;

  function automatic logic [15:0] crc16_upd(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c ^ {d, 8'h00};
    for (int i = 0; i < 8; i++) begin
      r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
    end
    return r;
  endfunction

  function automatic logic [7:0] crc_byte(input logic [7:0] b);
    return CRC_EN ? b : 8'h00;
  endfunction

  // The output register can take a new byte when empty or being consumed.
  assign adv  = !m_tvalid || m_tready;
  assign m_hs = m_tvalid && m_tready;
  // LEN_L looks ahead into the payload so the first payload byte follows
  // LEN_L without a bubble.
  assign pay_phase = (state == PAYLOAD) || (state == LEN_L && len_q != 16'd0);
  assign s_tready  = (pay_phase && adv && (cnt < len_q) && !pad) || (state == DRAIN);
  assign s_hs      = s_tvalid && s_tready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      hdr_ready <= 1'b0;
      m_tdata   <= 8'h00;
      m_tvalid  <= 1'b0;
      busy      <= 1'b0;
      len_err   <= 1'b0;
      crc       <= 16'hFFFF;
      cnt       <= 16'd0;
      len_q     <= 16'd0;
      type_q    <= 8'h00;
      pad       <= 1'b0;
      late      <= 1'b0;
    end else begin
      len_err <= 1'b0;
      case (state)
        IDLE: begin
          hdr_ready <= 1'b1;
          if (hdr_valid && hdr_ready) begin
            type_q <= hdr_type;
            len_q  <= hdr_len;
            crc    <= 16'hFFFF;
            cnt    <= 16'd0;
            pad    <= 1'b0;
            late   <= 1'b0;
            if ({1'b0, hdr_len} > MAX_LEN_W) begin
              len_err <= 1'b1;
            end else begin
              hdr_ready <= 1'b0;
              busy      <= 1'b1;
              m_tdata   <= 8'h5A;
              m_tvalid  <= 1'b1;
              state     <= SOF;
            end
          end
        end
        SOF: if (m_hs) begin
          m_tdata <= type_q;
          crc     <= crc16_upd(crc, type_q);
          state   <= TYPE;
        end
        TYPE: if (m_hs) begin
          m_tdata <= len_q[15:8];
          crc     <= crc16_upd(crc, len_q[15:8]);
          state   <= LEN_H;
        end
        LEN_H: if (m_hs) begin
          m_tdata <= len_q[7:0];
          crc     <= crc16_upd(crc, len_q[7:0]);
          state   <= LEN_L;
        end
        LEN_L, PAYLOAD: begin
          if (state == LEN_L && len_q == 16'd0) begin
            if (m_hs) begin
              m_tdata <= crc_byte(crc[15:8]);
              state   <= CRC_H;
            end
          end else if (cnt < len_q) begin
            if (pad) begin
              if (adv) begin
                m_tdata  <= 8'h00;
                m_tvalid <= 1'b1;
                crc      <= crc16_upd(crc, 8'h00);
                cnt      <= cnt + 16'd1;
                state    <= PAYLOAD;
              end
            end else if (s_hs) begin
              m_tdata  <= s_tdata;
              m_tvalid <= 1'b1;
              crc      <= crc16_upd(crc, s_tdata);
              cnt      <= cnt + 16'd1;
              state    <= PAYLOAD;
              if (s_tlast && (cnt + 16'd1 < len_q)) begin
                pad     <= 1'b1;
                len_err <= 1'b1;
              end
              if (!s_tlast && (cnt + 16'd1 == len_q)) begin
                late    <= 1'b1;
                len_err <= 1'b1;
              end
            end else if (m_hs) begin
              // Byte consumed, next payload byte not yet available.
              m_tvalid <= 1'b0;
              state    <= PAYLOAD;
            end
          end else if (m_hs) begin
            m_tdata <= crc_byte(crc[15:8]);
            state   <= CRC_H;
          end
        end
        CRC_H: if (m_hs) begin
          m_tdata <= crc_byte(crc[7:0]);
          state   <= CRC_L;
        end
        CRC_L: if (m_hs) begin
          m_tvalid <= 1'b0;
          if (late) begin
            state <= DRAIN;
          end else begin
            state     <= IDLE;
            busy      <= 1'b0;
            hdr_ready <= 1'b1;
          end
        end
        DRAIN: if (s_hs && s_tlast) begin
          state     <= IDLE;
          busy      <= 1'b0;
          hdr_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_pkt_framer.sv
module tb_uart_pkt_framer;

  logic        clk;
  logic        rst;
  logic        hdr_valid;
  logic [7:0]  hdr_type;
  logic [15:0] hdr_len;
  logic [7:0]  s_tdata;
  logic        s_tvalid;
  logic        s_tlast;
  logic        m_tready;

  logic        hdr_ready1, s_tready1, m_tvalid1, busy1, len_err1;
  logic [7:0]  m_tdata1;
  logic        hdr_ready0, s_tready0, m_tvalid0, busy0, len_err0;
  logic [7:0]  m_tdata0;

  uart_pkt_framer #(.MAX_LEN(1518), .CRC_EN(1'b1)) u1 (
    .clk(clk), .rst(rst), .hdr_valid(hdr_valid), .hdr_ready(hdr_ready1),
    .hdr_type(hdr_type), .hdr_len(hdr_len), .s_tdata(s_tdata), .s_tvalid(s_tvalid),
    .s_tready(s_tready1), .s_tlast(s_tlast), .m_tdata(m_tdata1), .m_tvalid(m_tvalid1),
    .m_tready(m_tready), .busy(busy1), .len_err(len_err1)
  );

  uart_pkt_framer #(.MAX_LEN(1518), .CRC_EN(1'b0)) u0 (
    .clk(clk), .rst(rst), .hdr_valid(hdr_valid), .hdr_ready(hdr_ready0),
    .hdr_type(hdr_type), .hdr_len(hdr_len), .s_tdata(s_tdata), .s_tvalid(s_tvalid),
    .s_tready(s_tready0), .s_tlast(s_tlast), .m_tdata(m_tdata0), .m_tvalid(m_tvalid0),
    .m_tready(m_tready), .busy(busy0), .len_err(len_err0)
  );

  int checks = 0;
  int failures = 0;
  int hs_cnt = 0;
  int lerr_cnt = 0;
  int rdy_mode = 0;
  logic watch_s = 1'b0;
  logic s_seen = 1'b0;

  logic [7:0]  exp_q[$];
  logic [7:0]  exp0_q[$];
  logic [8:0]  s_q[$];
  logic [7:0]  exp_pay[$];
  logic [15:0] mcrc;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    logic fb;
    r = c;
    for (int i = 7; i >= 0; i--) begin
      fb = r[15] ^ d[i];
      r  = {r[14:0], 1'b0};
      if (fb) r = r ^ 16'h1021;
    end
    return r;
  endfunction

  task automatic push_b(input logic [7:0] b);
    exp_q.push_back(b);
    exp0_q.push_back(b);
    mcrc = crc_step(mcrc, b);
  endtask

  task automatic push_frame(input logic [7:0] t, input logic [15:0] l);
    logic [7:0] b;
    mcrc = 16'hFFFF;
    exp_q.push_back(8'h5A);
    exp0_q.push_back(8'h5A);
    push_b(t);
    push_b(l[15:8]);
    push_b(l[7:0]);
    for (int i = 0; i < int'(l); i++) begin
      b = (i < exp_pay.size()) ? exp_pay[i] : 8'h00;
      push_b(b);
    end
    exp_q.push_back(mcrc[15:8]);
    exp_q.push_back(mcrc[7:0]);
    exp0_q.push_back(8'h00);
    exp0_q.push_back(8'h00);
  endtask

  task automatic send_hdr(input logic [7:0] t, input logic [15:0] l);
    int n;
    @(posedge clk); #1;
    hdr_type  = t;
    hdr_len   = l;
    hdr_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!hdr_ready1 && n < 300);
    if (!hdr_ready1) chk("hdr_accept_timeout", 32'(hdr_ready1), 32'd1);
    @(posedge clk); #1;
    hdr_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((exp_q.size() != 0 || exp0_q.size() != 0 || busy1) && n < 2000);
    if (n >= 2000) chk(name, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic wait_empty(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (exp_q.size() != 0 && n < 1000);
    if (n >= 1000) chk(name, 32'(exp_q.size()), 32'd0);
  endtask

  // m_tready generator
  initial begin
    m_tready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0: m_tready = 1'b1;
        1: m_tready = 1'($urandom_range(0, 1));
        default: m_tready = 1'b0;
      endcase
    end
  end

  // payload source
  initial begin
    logic hs;
    logic [8:0] tmp;
    s_tvalid = 1'b0;
    s_tdata  = 8'h00;
    s_tlast  = 1'b0;
    forever begin
      @(negedge clk);
      hs = s_tvalid && s_tready1;
      @(posedge clk); #1;
      if (hs && s_q.size() > 0) tmp = s_q.pop_front();
      if (s_q.size() > 0) begin
        {s_tlast, s_tdata} = s_q[0];
        s_tvalid = 1'b1;
      end else begin
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
      end
    end
  end

  // output monitor / scoreboard
  initial begin
    logic stall1, stall0;
    logic [7:0] sd1, sd0, e;
    stall1 = 1'b0;
    stall0 = 1'b0;
    sd1 = 8'h00;
    sd0 = 8'h00;
    forever begin
      @(negedge clk);
      if (rst) begin
        stall1 = 1'b0;
        stall0 = 1'b0;
      end else begin
        if (stall1) chk("m_hold_crc1", {23'd0, m_tvalid1, m_tdata1}, {23'd0, 1'b1, sd1});
        if (stall0) chk("m_hold_crc0", {23'd0, m_tvalid0, m_tdata0}, {23'd0, 1'b1, sd0});
        if (m_tvalid1 && m_tready) begin
          hs_cnt++;
          if (exp_q.size() == 0) chk("m_extra_byte_crc1", 32'(m_tdata1), 32'h100);
          else begin
            e = exp_q.pop_front();
            chk("m_byte_crc1", 32'(m_tdata1), 32'(e));
          end
        end
        if (m_tvalid0 && m_tready) begin
          if (exp0_q.size() == 0) chk("m_extra_byte_crc0", 32'(m_tdata0), 32'h100);
          else begin
            e = exp0_q.pop_front();
            chk("m_byte_crc0", 32'(m_tdata0), 32'(e));
          end
        end
        stall1 = m_tvalid1 && !m_tready;
        stall0 = m_tvalid0 && !m_tready;
        sd1 = m_tdata1;
        sd0 = m_tdata0;
        if (len_err1) lerr_cnt++;
        if (watch_s && s_tready1) s_seen = 1'b1;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int l0, h0;
    rst = 1'b1;
    hdr_valid = 1'b0;
    hdr_type = 8'h00;
    hdr_len = 16'h0000;

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_m_tvalid", 32'(m_tvalid1), 32'd0);
    chk("rst_m_tdata", 32'(m_tdata1), 32'd0);
    chk("rst_busy", 32'(busy1), 32'd0);
    chk("rst_len_err", 32'(len_err1), 32'd0);
    chk("rst_hdr_ready", 32'(hdr_ready1), 32'd0);
    chk("rst_s_tready", 32'(s_tready1), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_hdr_ready", 32'(hdr_ready1), 32'd1);

    // T1: back-to-back 8-byte frame
    rdy_mode = 0;
    exp_pay = '{8'h00, 8'h01};
    s_q.push_back({1'b0, 8'h00});
    s_q.push_back({1'b1, 8'h01});
    push_frame(8'h01, 16'd2);
    l0 = lerr_cnt;
    send_hdr(8'h01, 16'd2);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("t1_consecutive_tvalid", 32'(m_tvalid1), 32'd1);
    end
    @(negedge clk);
    chk("t1_tvalid_after", 32'(m_tvalid1), 32'd0);
    chk("t1_busy_after", 32'(busy1), 32'd0);
    chk("t1_queue_empty", 32'(exp0_q.size()), 32'd0);
    chk("t1_len_err", 32'(lerr_cnt - l0), 32'd0);

    // T2: 16-byte payload with random back-pressure
    rdy_mode = 1;
    exp_pay.delete();
    for (int i = 0; i < 16; i++) begin
      exp_pay.push_back(8'(8'h41 + i));
      s_q.push_back({(i == 15), 8'(8'h41 + i)});
    end
    push_frame(8'h10, 16'd16);
    l0 = lerr_cnt;
    h0 = hs_cnt;
    send_hdr(8'h10, 16'd16);
    wait_done("t2_timeout");
    chk("t2_frame_len", 32'(hs_cnt - h0), 32'd22);
    chk("t2_len_err", 32'(lerr_cnt - l0), 32'd0);
    rdy_mode = 0;

    // T3: zero-length payload
    exp_pay.delete();
    s_seen = 1'b0;
    watch_s = 1'b1;
    push_frame(8'h02, 16'd0);
    h0 = hs_cnt;
    send_hdr(8'h02, 16'd0);
    wait_done("t3_timeout");
    watch_s = 1'b0;
    chk("t3_s_tready_seen", 32'(s_seen), 32'd0);
    chk("t3_frame_len", 32'(hs_cnt - h0), 32'd6);

    // T4: early tlast, zero fill
    exp_pay = '{8'hAA, 8'hBB};
    s_q.push_back({1'b0, 8'hAA});
    s_q.push_back({1'b1, 8'hBB});
    push_frame(8'h03, 16'd4);
    l0 = lerr_cnt;
    h0 = hs_cnt;
    send_hdr(8'h03, 16'd4);
    wait_done("t4_timeout");
    chk("t4_frame_len", 32'(hs_cnt - h0), 32'd10);
    chk("t4_len_err", 32'(lerr_cnt - l0), 32'd1);

    // T5: late tlast, drain
    exp_pay = '{8'hC1, 8'hC2};
    s_q.push_back({1'b0, 8'hC1});
    s_q.push_back({1'b0, 8'hC2});
    push_frame(8'h04, 16'd2);
    l0 = lerr_cnt;
    h0 = hs_cnt;
    send_hdr(8'h04, 16'd2);
    wait_empty("t5_timeout");
    repeat (5) @(negedge clk);
    chk("t5_busy_in_drain", 32'(busy1), 32'd1);
    chk("t5_hdr_ready_in_drain", 32'(hdr_ready1), 32'd0);
    chk("t5_len_err", 32'(lerr_cnt - l0), 32'd1);
    chk("t5_frame_len", 32'(hs_cnt - h0), 32'd8);
    s_q.push_back({1'b0, 8'hC3});
    s_q.push_back({1'b1, 8'hC4});
    wait_done("t5_drain_timeout");
    chk("t5_hdr_ready_after", 32'(hdr_ready1), 32'd1);
    chk("t5_drained", 32'(s_q.size()), 32'd0);
    chk("t5_frame_len_after", 32'(hs_cnt - h0), 32'd8);

    // T6: oversize header rejected
    l0 = lerr_cnt;
    h0 = hs_cnt;
    send_hdr(8'h05, 16'd1519);
    repeat (6) @(negedge clk);
    chk("t6_no_tvalid", 32'(m_tvalid1), 32'd0);
    chk("t6_busy", 32'(busy1), 32'd0);
    chk("t6_len_err", 32'(lerr_cnt - l0), 32'd1);
    chk("t6_no_bytes", 32'(hs_cnt - h0), 32'd0);

    // T7: reset during payload, then a clean frame
    exp_pay.delete();
    mcrc = 16'hFFFF;
    exp_q.push_back(8'h5A);
    exp0_q.push_back(8'h5A);
    push_b(8'h06); push_b(8'h00); push_b(8'h08);
    push_b(8'h11); push_b(8'h22); push_b(8'h33);
    s_q.push_back({1'b0, 8'h11});
    s_q.push_back({1'b0, 8'h22});
    s_q.push_back({1'b0, 8'h33});
    send_hdr(8'h06, 16'd8);
    wait_empty("t7_prefix_timeout");
    rdy_mode = 2;
    repeat (2) @(posedge clk);
    s_q.push_back({1'b0, 8'h44});
    repeat (4) @(negedge clk);
    chk("t7_stalled_valid", 32'(m_tvalid1), 32'd1);
    chk("t7_stalled_data", 32'(m_tdata1), 32'h44);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    chk("t7_rst_tvalid", 32'(m_tvalid1), 32'd0);
    chk("t7_rst_tvalid_crc0", 32'(m_tvalid0), 32'd0);
    chk("t7_rst_busy", 32'(busy1), 32'd0);
    exp_q.delete();
    exp0_q.delete();
    s_q.delete();
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    rdy_mode = 0;
    exp_pay = '{8'h99};
    s_q.push_back({1'b1, 8'h99});
    push_frame(8'h81, 16'd1);
    h0 = hs_cnt;
    send_hdr(8'h81, 16'd1);
    @(negedge clk);
    chk("t7_clean_sof", {24'd0, m_tdata1}, 32'h5A);
    wait_done("t7_timeout");
    chk("t7_frame_len", 32'(hs_cnt - h0), 32'd7);

    repeat (3) @(negedge clk);
    chk("end_queue_empty", 32'(exp_q.size() + exp0_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
